// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter (fetch + data) sharing one single-cycle memory.
// Grant is combinational in the request cycle; response valid/rdata exactly one cycle later.
// Requesters hold their request until granted; a held request is granted within 2 cycles.
module mem_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32   // byte enables are 4 bits wide, so this must stay 32
) (
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic              if_valid_o,
    output logic [DATA_W-1:0] if_rdata_o,
    input  logic              dm_req_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [3:0]        dm_wr_en_i,
    input  logic [1:0]        dm_rd_en_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic              dm_gnt_o,
    output logic              dm_valid_o,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [3:0]        mem_wr_en_o,
    output logic [1:0]        mem_rd_en_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DM   = 2'd2
    } owner_e;

    typedef enum logic {
        LAST_IF = 1'b0,
        LAST_DM = 1'b1
    } last_e;

    owner_e resp_owner, resp_owner_nxt;
    last_e  last_winner, last_winner_nxt;
    logic   if_win, dm_win;

    // Pick the winner: a lone request wins, contention alternates away from the
    // previous winner. Nothing is granted while reset is held.
    always_comb begin
        if_win = 1'b0;
        dm_win = 1'b0;
        if (!reset_i) begin
            if (if_req_i && dm_req_i) begin
                if (last_winner == LAST_IF) begin
                    dm_win = 1'b1;
                end else begin
                    if_win = 1'b1;
                end
            end else begin
                if_win = if_req_i;
                dm_win = dm_req_i;
            end
        end
    end

    assign if_gnt_o = if_win;
    assign dm_gnt_o = dm_win;

    // Next state: the grant decides who owns next cycle's response and becomes
    // the new round-robin reference; an idle cycle leaves last_winner alone.
    always_comb begin
        resp_owner_nxt  = OWN_NONE;
        last_winner_nxt = last_winner;
        if (if_win) begin
            resp_owner_nxt  = OWN_IF;
            last_winner_nxt = LAST_IF;
        end else if (dm_win) begin
            resp_owner_nxt  = OWN_DM;
            last_winner_nxt = LAST_DM;
        end
    end

    // State registers; async reset drops any in-flight response.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            resp_owner  <= OWN_NONE;
            last_winner <= LAST_IF;
        end else begin
            resp_owner  <= resp_owner_nxt;
            last_winner <= last_winner_nxt;
        end
    end

    // Steer the winner's command onto the shared memory bus; idle bus is all zero.
    always_comb begin
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        mem_wr_en_o = 4'b0000;
        mem_rd_en_o = 2'b00;
        if (if_win) begin
            mem_addr_o  = if_addr_i;
            mem_rd_en_o = 2'b10;
        end else if (dm_win) begin
            mem_addr_o  = dm_addr_i;
            mem_wdata_o = dm_wdata_i;
            mem_wr_en_o = dm_wr_en_i;
            mem_rd_en_o = dm_rd_en_i;
        end
    end

    // Route the memory response to the port that owns this cycle; the other port sees zero.
    always_comb begin
        if_valid_o = (resp_owner == OWN_IF);
        dm_valid_o = (resp_owner == OWN_DM);
        if_rdata_o = if_valid_o ? mem_rdata_i : '0;
        dm_rdata_o = dm_valid_o ? mem_rdata_i : '0;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 32, meaning: width of all address buses.
REQ-002 Parameter DATA_W, default 32, meaning: width of data buses; SHALL be 32, because byte enables are fixed at 4 bits.
REQ-003 clock_i  input  1  single clock; all state updates on its rising edge.
REQ-004 reset_i  input  1  asynchronous, active-high reset.
REQ-005 if_req_i  input  1  fetch port: read request.
REQ-006 if_addr_i  input  ADDR_W  fetch port: read address.
REQ-007 if_gnt_o  output  1  fetch port: request accepted this cycle.
REQ-008 if_valid_o  output  1  fetch port: read data valid.
REQ-009 if_rdata_o  output  DATA_W  fetch port: instruction word.
REQ-010 dm_req_i  input  1  data port: access request.
REQ-011 dm_addr_i  input  ADDR_W  data port: access address.
REQ-012 dm_wr_en_i  input  4  data port: byte write enables; nonzero means write.
REQ-013 dm_rd_en_i  input  2  data port: load size code, passed through.
REQ-014 dm_wdata_i  input  DATA_W  data port: store data.
REQ-015 dm_gnt_o, dm_valid_o  output  1 each  data port: grant and response, same meanings as the fetch port.
REQ-016 dm_rdata_o  output  DATA_W  data port: load data.
REQ-017 mem_addr_o, mem_wdata_o  output  ADDR_W, DATA_W  shared memory: address and write data.
REQ-018 mem_wr_en_o, mem_rd_en_o  output  4, 2  shared memory: byte write enables and read enable/size.
REQ-019 mem_rdata_i  input  DATA_W  shared memory: read data, valid one cycle after the address is presented.

Function
REQ-020 The arbiter SHALL keep two registered states: resp_owner (NONE/IF/DM) and last_winner (IF/DM).
REQ-021 Grant cycle N: if exactly one req is high, that requester SHALL win; the same cycle, gnt_o=1 and its addr/enables/wdata are driven combinationally onto mem_*.
REQ-022 When both reqs are high, the winner SHALL be the port that is not last_winner (round-robin); after reset last_winner=IF, so DM wins the first contention.
REQ-023 The fetch port SHALL drive mem_wr_en_o=0 and mem_rd_en_o=2'b10 (word); the data port SHALL pass through dm_wr_en_i and dm_rd_en_i.
REQ-024 With no grant, mem_wr_en_o=0, mem_rd_en_o=0, mem_addr_o=0, mem_wdata_o=0.
REQ-025 On each grant edge, resp_owner SHALL be set to the winner and last_winner updated; with no grant, resp_owner SHALL be set to NONE.
REQ-026 Cycle N+1: the x_valid_o selected by resp_owner SHALL be 1 and x_rdata_o=mem_rdata_i; the other valid SHALL be 0 and its rdata 0.
REQ-027 Writes SHALL also produce valid at N+1; their dm_rdata_o value is don't-care.
REQ-028 A new grant MAY occur in the same cycle as a response; sustained throughput SHALL be one access per cycle.
REQ-029 Requesters hold req/addr/data stable until gnt; the arbiter SHALL NOT latch inputs before grant.
REQ-030 A req dropped before grant SHALL cause no memory access.
REQ-031 At most one grant per cycle; if_gnt_o and dm_gnt_o SHALL never both be 1.
REQ-032 Latency from grant to valid SHALL be exactly 1 cycle; no starvation: a held request SHALL be granted within 2 cycles.

Reset
REQ-033 While reset_i=1: resp_owner=NONE, last_winner=IF, all gnt_o/valid_o/rdata_o=0, and mem_wr_en_o=mem_rd_en_o=0, regardless of req inputs.
REQ-034 Reset asserted between grant and response SHALL discard the response (no valid after reset release); a write granted before the reset edge is not retracted.
REQ-035 The first grant after reset release SHALL occur on the first rising edge with reset_i=0 and a req high.

Verification
REQ-036 Only if_req_i=1, if_addr_i=0x10, mem returns 0x00500093 -> if_gnt_o=1 at N, if_valid_o=1 with if_rdata_o=0x00500093 at N+1.
REQ-037 Both reqs held 4 cycles after reset -> grants DM, IF, DM, IF; valids follow one cycle later.
REQ-038 dm_wr_en_i=4'b0011, dm_addr_i=0x100, dm_wdata_i=0xAABBCCDD -> mem_wr_en_o=0011, mem_addr_o=0x100 only in the grant cycle; dm_valid_o=1 next cycle.
REQ-039 Back-to-back fetches at 0x0, 0x4, 0x8 -> three consecutive gnt cycles, with if_valid_o high for three cycles starting one cycle later.
REQ-040 reset_i pulsed mid-cycle after a DM grant -> outputs zero asynchronously; no dm_valid_o after release; next contention grants DM.
REQ-041 A random bench with a scoreboarded memory model -> never two grants in one cycle, and every grant followed by exactly one valid to the same port.
